wb_pass_queue: RTL and testbench

- Parametrised successor to the action/writeback glue. Buffers writeback packets between the action stage and the register file / program-status write port.
- Packet fields: reg_write, reg_addr, reg_data, ps_write, ps_data.
- Replaces the direct combinational pass with a DEPTH-entry valid/ready queue. Adds pipeline flush and youngest-match register forwarding for the decode stage.

---
 rtl/wb_pass_queue.sv | 134 +++++++++++++
 tb/tb_wb_pass_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pass_queue.sv
// rtl/wb_pass_queue.sv - writeback packet queue with flush and youngest-match forwarding
// Optional zero-latency empty-queue bypass is enabled by defining WB_PASS_BYPASS_EN.
module wb_pass_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int PS_W   = 4,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_reg_write,
  input  logic [ADDR_W-1:0]          in_reg_addr,
  input  logic [DATA_W-1:0]          in_reg_data,
  input  logic                       in_ps_write,
  input  logic [PS_W-1:0]            in_ps_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_reg_write,
  output logic [ADDR_W-1:0]          out_reg_addr,
  output logic [DATA_W-1:0]          out_reg_data,
  output logic                       out_ps_write,
  output logic [PS_W-1:0]            out_ps_data,
  input  logic [ADDR_W-1:0]          fwd_addr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic              mem_rw   [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_pw   [DEPTH];
  logic [PS_W-1:0]   mem_ps   [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             head_valid, bypass, do_push, do_pop;

  // Pointers wrap explicitly at DEPTH-1, so any depth works
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= DEPTH) s -= DEPTH;
    return PTR_W'(s);
  endfunction

  assign head_valid = (cnt != '0);
  assign in_ready   = (cnt != FULL);
  assign count      = cnt;

`ifdef WB_PASS_BYPASS_EN
  assign bypass = !head_valid && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = head_valid || bypass;
  assign do_pop    = head_valid && out_ready;
  // A bypassed packet that the consumer takes immediately is never stored
  assign do_push   = in_valid && in_ready && !flush && !(bypass && out_ready);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_rw[wr_ptr]   <= in_reg_write;
      mem_addr[wr_ptr] <= in_reg_addr;
      mem_data[wr_ptr] <= in_reg_data;
      mem_pw[wr_ptr]   <= in_ps_write;
      mem_ps[wr_ptr]   <= in_ps_data;
    end
  end

  always_comb begin
    out_reg_write = 1'b0;
    out_reg_addr  = '0;
    out_reg_data  = '0;
    out_ps_write  = 1'b0;
    out_ps_data   = '0;
    if (bypass) begin
      out_reg_write = in_reg_write;
      out_reg_addr  = in_reg_addr;
      out_reg_data  = in_reg_data;
      out_ps_write  = in_ps_write;
      out_ps_data   = in_ps_data;
    end else if (head_valid) begin
      out_reg_write = mem_rw[rd_ptr];
      out_reg_addr  = mem_addr[rd_ptr];
      out_reg_data  = mem_data[rd_ptr];
      out_ps_write  = mem_pw[rd_ptr];
      out_ps_data   = mem_ps[rd_ptr];
    end
  end

  // Walk oldest to youngest so the last match (the youngest) wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(cnt) && mem_rw[slot_of(rd_ptr, k)] &&
          mem_addr[slot_of(rd_ptr, k)] == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_data[slot_of(rd_ptr, k)];
      end
    end
  end

endmodule

// File: tb/tb_wb_pass_queue.sv
// tb/tb_wb_pass_queue.sv - scoreboard bench for wb_pass_queue (DEPTH=3)
// Expected packets are queued at issue time; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_wb_pass_queue;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int PW = 4;
  localparam int DEPTH = 3;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef WB_PASS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic          in_reg_write, in_ps_write;
  logic [AW-1:0] in_reg_addr;
  logic [DW-1:0] in_reg_data;
  logic [PW-1:0] in_ps_data;
  logic          out_valid, out_ready, out_reg_write, out_ps_write;
  logic [AW-1:0] out_reg_addr;
  logic [DW-1:0] out_reg_data;
  logic [PW-1:0] out_ps_data;
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;
  logic [24:0] expq [$];

  wb_pass_queue #(.DATA_W(DW), .ADDR_W(AW), .PS_W(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_reg_addr(in_reg_addr), .in_reg_data(in_reg_data),
    .in_ps_write(in_ps_write), .in_ps_data(in_ps_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_write(out_reg_write), .out_reg_addr(out_reg_addr), .out_reg_data(out_reg_data),
    .out_ps_write(out_ps_write), .out_ps_data(out_ps_data),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (%0d compared)", n_cmp);
    $fatal(1);
  end

  function automatic logic [24:0] pk(input logic rw, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d, input logic pw,
                                     input logic [PW-1:0] ps);
    return {rw, a, d, pw, ps};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [24:0] p);
    {in_reg_write, in_reg_addr, in_reg_data, in_ps_write, in_ps_data} = p;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [24:0] p);
    int n = 0;
    drive(p);
    expq.push_back(p);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (count != '0 && n < 50) begin
      step(1);
      n++;
    end
    check(name, 32'(count), 32'd0);
  endtask

  // Scoreboard monitor: every consumer handshake must match the oldest expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got 0x%0h expected none at %0t",
                   {out_reg_write, out_reg_addr, out_reg_data, out_ps_write, out_ps_data}, $time);
        end else begin
          check("out_pkt", 32'({out_reg_write, out_reg_addr, out_reg_data, out_ps_write, out_ps_data}),
                32'(expq.pop_front()));
        end
      end
      if (!out_valid)
        check("idle_fields_zero",
              32'({out_reg_write, out_reg_addr, out_reg_data, out_ps_write, out_ps_data}), 32'd0);
      check("count_le_depth", 32'(count <= CW'(DEPTH)), 32'd1);
    end
  end

  // Producer must hold its packet while stalled
  logic        hold_prev = 1'b0;
  logic [24:0] prev_pkt = '0;
  always @(posedge clk) begin
    if (!rst && hold_prev &&
        (!in_valid || {in_reg_write, in_reg_addr, in_reg_data, in_ps_write, in_ps_data} != prev_pkt))
      $error("producer changed a stalled packet");
    hold_prev <= in_valid && !in_ready && !flush;
    prev_pkt  <= {in_reg_write, in_reg_addr, in_reg_data, in_ps_write, in_ps_data};
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fwd_addr = '0;
    {in_reg_write, in_reg_addr, in_reg_data, in_ps_write, in_ps_data} = '0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fwd", 32'({fwd_hit, fwd_data}), 32'd0);
    step(1);

    // Single packet with consumer ready
    out_ready = 1'b1;
    send(pk(1'b1, 3'd3, 16'h1234, 1'b0, 4'h0));
    step(2);
    check("single_count_back_to_0", 32'(count), 32'd0);
    check("single_out_valid_low", 32'(out_valid), 32'd0);

    // Fill and backpressure
    out_ready = 1'b0;
    send(pk(1'b1, 3'd1, 16'h0001, 1'b1, 4'h1));
    send(pk(1'b0, 3'd2, 16'h0002, 1'b0, 4'h2));
    send(pk(1'b1, 3'd3, 16'h0003, 1'b1, 4'h3));
    check("full_count", 32'(count), 32'd3);
    check("full_in_ready", 32'(in_ready), 32'd0);
    drive(pk(1'b1, 3'd4, 16'h0004, 1'b0, 4'h4));
    expq.push_back(pk(1'b1, 3'd4, 16'h0004, 1'b0, 4'h4));
    step(2);
    check("held_count", 32'(count), 32'd3);
    check("held_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      check("held_accepted", 32'(in_ready), 32'd1);
    end
    step(1);
    in_valid = 1'b0;
    wait_empty("fill_drain");
    check("fill_all_delivered", 32'(expq.size()), 32'd0);

    // Wrap-around with mixed simultaneous push/pop
    for (int i = 0; i < 10; i++) begin
      out_ready = (i % 3 != 2);
      send(pk(1'(i % 2), 3'(i % 8), 16'(i), 1'b1, 4'(i)));
    end
    out_ready = 1'b1;
    wait_empty("wrap_drain");
    step(1);
    check("wrap_all_delivered", 32'(expq.size()), 32'd0);

    // Forwarding priority: youngest writer wins, rw=0 entries never match
    out_ready = 1'b0;
    send(pk(1'b1, 3'd5, 16'hAAAA, 1'b0, 4'h0));
    send(pk(1'b1, 3'd5, 16'hBBBB, 1'b1, 4'h5));
    send(pk(1'b0, 3'd5, 16'hCCCC, 1'b0, 4'h0));
    fwd_addr = 3'd5;
    @(negedge clk);
    check("fwd5_hit", 32'(fwd_hit), 32'd1);
    check("fwd5_data", 32'(fwd_data), 32'hBBBB);
    fwd_addr = 3'd2;
    @(negedge clk);
    check("fwd2_miss", 32'({fwd_hit, fwd_data}), 32'd0);
    fwd_addr = 3'd5;

    // Flush with concurrent push: everything including the new packet vanishes
    step(1);
    flush = 1'b1;
    drive(pk(1'b1, 3'd5, 16'hDDDD, 1'b0, 4'h0));
    step(1);
    flush = 1'b0;
    in_valid = 1'b0;
    expq.delete();
    @(negedge clk);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_fwd_stale", 32'({fwd_hit, fwd_data}), 32'd0);
    out_ready = 1'b1;
    step(4);
    check("flush_stays_empty", 32'(count), 32'd0);

    // Reset mid-operation discards entries
    out_ready = 1'b0;
    send(pk(1'b1, 3'd6, 16'h6666, 1'b0, 4'h6));
    send(pk(1'b1, 3'd7, 16'h7777, 1'b0, 4'h7));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expq.delete();
    @(negedge clk);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_fwd", 32'(fwd_hit), 32'd0);
    step(1);

    // Empty-queue latency: same cycle with bypass, one cycle later without
    out_ready = 1'b1;
    drive(pk(1'b1, 3'd2, 16'h5A5A, 1'b0, 4'h0));
    expq.push_back(pk(1'b1, 3'd2, 16'h5A5A, 1'b0, 4'h0));
    @(negedge clk);
    check("byp_same_valid", 32'(out_valid), 32'(BYP));
    check("byp_same_data", 32'(out_reg_data), BYP ? 32'h5A5A : 32'h0);
    step(1);
    in_valid = 1'b0;
    check("byp_count_after", 32'(count), BYP ? 32'd0 : 32'd1);
    @(negedge clk);
    check("byp_next_valid", 32'(out_valid), 32'(!BYP));
    check("byp_next_data", 32'(out_reg_data), BYP ? 32'h0 : 32'h5A5A);
    step(2);
    check("final_all_delivered", 32'(expq.size()), 32'd0);
    check("final_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
